// File: rtl/event_header_reader.sv
// Reads completed event headers out of the four-buffer header RAM in completion order,
// streams them over valid/ready and releases each buffer. Optional checksum word: EVENT_HEADER_READER_CHECKSUM_EN.
module event_header_reader #(
    parameter int HEADER_WORDS = 22,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                           clk33_i,
    input  logic                           rst_n_i,
    input  logic                           event_done_i,
    input  logic [1:0]                     event_buffer_i,
    output logic [7:0]                     ram_addr_o,
    input  logic [15:0]                    ram_dat_i,
    output logic [15:0]                    hdr_dat_o,
    output logic                           hdr_valid_o,
    output logic                           hdr_last_o,
    input  logic                           hdr_ready_i,
    output logic                           buf_clear_o,
    output logic [1:0]                     buf_clear_id_o,
    output logic [$clog2(QUEUE_DEPTH):0]   pending_o,
    output logic                           overflow_o,
    output logic [2:0]                     dbg_state_o
);

    localparam int          AW         = $clog2(QUEUE_DEPTH);
    localparam logic [5:0]  LAST_WORD  = 6'(HEADER_WORDS - 1);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        PRESENT = 3'd3,
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
        CSUM    = 3'd4,
`endif
        RELEASE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      queue_q [QUEUE_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [1:0]      cur_buf_q;
    logic [5:0]      word_q;
    logic            accept, pop, push_ok;
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
    logic [15:0]     sum_q;
`endif

    // Handshake: a word transfers on any clock edge where hdr_valid_o && hdr_ready_i;
    // once raised, hdr_valid_o/hdr_dat_o/hdr_last_o stay put until that transfer.
    assign accept  = hdr_valid_o && hdr_ready_i;
    assign pop     = (state_q == RELEASE);
    // A pop frees the slot in the same edge, so a full queue still takes the push.
    assign push_ok = event_done_i && ((count_q != FULL_COUNT) || pop);

    assign ram_addr_o     = {cur_buf_q, word_q};
    assign buf_clear_o    = pop;
    assign buf_clear_id_o = pop ? cur_buf_q : 2'b00;
    assign pending_o      = count_q;
    assign dbg_state_o    = state_q;

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= 2'b00;
        end else begin
            if (push_ok) begin
                queue_q[wr_ptr_q] <= event_buffer_i;
                wr_ptr_q          <= wr_ptr_q + AW'(1);
            end
            if (event_done_i && !push_ok) overflow_o <= 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = RD_ADDR;
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = PRESENT;
            PRESENT: begin
                if (accept) begin
                    if (word_q == LAST_WORD) begin
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = RELEASE;
`endif
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
            CSUM:    if (accept) state_d = RELEASE;
`endif
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_buf_q   <= 2'b00;
            word_q      <= 6'd0;
            hdr_dat_o   <= 16'h0000;
            hdr_valid_o <= 1'b0;
            hdr_last_o  <= 1'b0;
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
            sum_q       <= 16'h0000;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
                    sum_q <= 16'h0000;
`endif
                    if (count_q != '0) begin
                        cur_buf_q <= queue_q[rd_ptr_q];
                        word_q    <= 6'd0;
                    end
                end
                RD_WAIT: begin
                    hdr_dat_o   <= ram_dat_i;
                    hdr_valid_o <= 1'b1;
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
                    hdr_last_o  <= 1'b0;
`else
                    hdr_last_o  <= (word_q == LAST_WORD);
`endif
                end
                PRESENT: begin
                    if (accept) begin
                        hdr_valid_o <= 1'b0;
                        hdr_last_o  <= 1'b0;
                        if (word_q != LAST_WORD) word_q <= word_q + 6'd1;
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
                        sum_q <= sum_q + hdr_dat_o;
`endif
                    end
                end
`ifdef EVENT_HEADER_READER_CHECKSUM_EN
                // First CSUM cycle loads the two's complement of the sum, then waits for acceptance.
                CSUM: begin
                    if (!hdr_valid_o) begin
                        hdr_dat_o   <= ~sum_q + 16'd1;
                        hdr_valid_o <= 1'b1;
                        hdr_last_o  <= 1'b1;
                    end else if (hdr_ready_i) begin
                        hdr_valid_o <= 1'b0;
                        hdr_last_o  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
